core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Arbitrates the core's instruction-fetch port and data load/store port onto one single-port memory bus.
- Sits between the Core pipeline and unified instruction/data memory; one transaction is outstanding at a time.
- Memory latency is variable, with handshake by M_ACK; a watchdog aborts transactions the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; must be a multiple of 8.
- TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_REQ  in  1  fetch request; held with I_ADDR until I_READY.
- I_ADDR  in  ADDR_W  fetch address.
- I_RDATA  out  DATA_W  fetch data; valid when I_READY=1.
- I_READY  out  1  one-cycle completion pulse for fetch.
- D_REQ  in  1  data request; held with payload until D_READY.
- D_WE  in  1  1=store, 0=load.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  store data.
- D_WSTRB  in  DATA_W/8  byte enables for store.
- D_RDATA  out  DATA_W  load data; valid when D_READY=1.
- D_READY  out  1  one-cycle completion pulse for data.
- BUS_ERR  out  1  high with READY when the transaction timed out.
- M_REQ  out  1  memory request, held until M_ACK or abort.
- M_WE, M_ADDR, M_WDATA, M_WSTRB  out  1/ADDR_W/DATA_W/DATA_W/8  registered memory payload.
- M_RDATA  in  DATA_W  memory read data; valid with M_ACK.
- M_ACK  in  1  memory completion; sampled only while M_REQ=1.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. All outputs are driven from registered state except READY/RDATA/BUS_ERR, which are combinational from state, M_ACK and the watchdog.
- IDLE:
  - D_REQ alone goes to BUSY_D; I_REQ alone goes to BUSY_I; neither stays in IDLE.
  - When both request, D wins (fixed priority; see Optional Feature).
  - On the grant edge, the winner's payload is latched into M_*. For an I grant, M_WE=0, M_WSTRB=0 and M_WDATA=0.
- BUSY_x:
  - M_REQ=1 and M_* are held stable.
  - On M_ACK=1, x_READY=1 and x_RDATA=M_RDATA in the same cycle; next state is IDLE and M_REQ drops. On a store, RDATA is don't-care.
  - Non-granted READY stays 0. When not ready, RDATA outputs are 0.
- Latency: REQ sampled at edge n, M_REQ high in cycle n+1; with immediate ACK, READY is in cycle n+1. The mandatory IDLE bubble gives a back-to-back throughput of 1 transaction per 2 cycles.
- Watchdog:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without ACK.
  - When the count equals TIMEOUT-1 and M_ACK=0, x_READY=1 and BUS_ERR=1 for that cycle, RDATA=0, then IDLE with M_REQ=0.
  - ACK in the same cycle as expiry takes precedence: normal completion, BUS_ERR=0.
- M_ACK while IDLE is ignored. Requester payload changes while BUSY are ignored because the payload is latched.
- Reset (RESET=0, any time):
  - State goes to IDLE; M_REQ, M_WE, M_ADDR, M_WDATA, M_WSTRB, counter and last-grant go to 0 immediately. Last-grant 0 means I was last served.
  - I_READY, D_READY, BUS_ERR and RDATA read 0.
  - An in-flight transaction is dropped without READY; the memory side must discard it.
- Releasing reset takes effect at the next CLK edge; arbitration resumes from IDLE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on contention. A last-grant register updates on every grant; when both request, the requester not last served wins. With last-grant=0 after reset, the first tie goes to D. A lone request is always granted.
- Undefined: fixed D-over-I priority; the last-grant register is not instantiated. A permanently requesting D port may starve I, and this is accepted.

Test Plan:
- Reset then I_REQ, I_ADDR=0x0000_0010, memory ACKs 2 cycles after M_REQ with M_RDATA=0x0050_0093 -> M_ADDR=0x10, M_WE=0; I_READY pulse 1 cycle with I_RDATA=0x0050_0093; BUS_ERR=0.
- D store: D_ADDR=0x100, D_WDATA=0xDEAD_BEEF, D_WSTRB=4'b0011, immediate ACK -> M_WE=1, M_WSTRB=4'b0011; D_READY in cycle after REQ sampled; next grant no earlier than 2 cycles later.
- I_REQ and D_REQ asserted continuously, ACK always immediate -> without macro, the grant sequence is D,D,D,…. With MEM_ARB_RR_EN, the grant sequence is D,I,D,I.
- TIMEOUT=4, D load, M_ACK held 0 -> D_READY=1 and BUS_ERR=1 in the 4th BUSY cycle, D_RDATA=0, M_REQ=0 next cycle. Second run with ACK in the 4th cycle -> BUS_ERR=0.
- RESET driven low mid-BUSY_I between clock edges -> M_REQ=0 and I_READY=0 asynchronously; after release with I_REQ high, a fresh grant occurs with M_ADDR re-latched.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Fetch/data arbiter onto one single-port memory bus, with one transaction outstanding and a watchdog abort.
// Optional MEM_ARB_RR_EN: round-robin on contention (default build: fixed D-over-I priority).
module core_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic [DATA_W-1:0]   I_RDATA,
  output logic                I_READY,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  input  logic [DATA_W/8-1:0] D_WSTRB,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                D_READY,
  output logic                BUS_ERR,
  output logic                M_REQ,
  output logic                M_WE,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic                M_ACK
);

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [DATA_W/8-1:0] r_m_wstrb;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_busy;
  logic                w_expire;
  logic                w_done;
  logic                w_tie_d;
  logic                w_grant_d;
  logic                w_grant_i;

`ifdef MEM_ARB_RR_EN
  // r_last_d=1 means D was served last; on a tie the other requester wins.
  logic r_last_d;
  assign w_tie_d = ~r_last_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d || w_grant_i) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_tie_d = 1'b1;
`endif

  assign w_busy    = (r_state != ST_IDLE);
  assign w_expire  = TO_EN && w_busy && !M_ACK && (r_cnt == TO_LAST);
  assign w_done    = w_busy && (M_ACK || w_expire);
  assign w_grant_d = (r_state == ST_IDLE) && D_REQ && (!I_REQ || w_tie_d);
  assign w_grant_i = (r_state == ST_IDLE) && I_REQ && !w_grant_d;

  assign M_REQ   = r_m_req;
  assign M_WE    = r_m_we;
  assign M_ADDR  = r_m_addr;
  assign M_WDATA = r_m_wdata;
  assign M_WSTRB = r_m_wstrb;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    I_READY = 1'b0;
    D_READY = 1'b0;
    BUS_ERR = 1'b0;
    I_RDATA = '0;
    D_RDATA = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_next = ST_BUSY_D;
        end else if (w_grant_i) begin
          w_next = ST_BUSY_I;
        end
      end
      ST_BUSY_I: begin
        if (w_done) begin
          w_next  = ST_IDLE;
          I_READY = 1'b1;
          BUS_ERR = w_expire;
          if (M_ACK) I_RDATA = M_RDATA;
        end
      end
      ST_BUSY_D: begin
        if (w_done) begin
          w_next  = ST_IDLE;
          D_READY = 1'b1;
          BUS_ERR = w_expire;
          if (M_ACK) D_RDATA = M_RDATA;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Payload is captured only on the grant edge so requester changes mid-transaction are invisible to memory.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_wstrb <= '0;
      r_cnt     <= '0;
    end else if (w_grant_d) begin
      r_m_req   <= 1'b1;
      r_m_we    <= D_WE;
      r_m_addr  <= D_ADDR;
      r_m_wdata <= D_WDATA;
      r_m_wstrb <= D_WSTRB;
      r_cnt     <= '0;
    end else if (w_grant_i) begin
      r_m_req   <= 1'b1;
      r_m_we    <= 1'b0;
      r_m_addr  <= I_ADDR;
      r_m_wdata <= '0;
      r_m_wstrb <= '0;
      r_cnt     <= '0;
    end else if (w_done) begin
      r_m_req <= 1'b0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: directed transactions push expectations, a monitor checks completions.
module tb_core_mem_arbiter;

  logic        CLK, RESET;
  logic        I_REQ, I_READY, D_REQ, D_WE, D_READY, BUS_ERR;
  logic [31:0] I_ADDR, I_RDATA, D_ADDR, D_WDATA, D_RDATA;
  logic [3:0]  D_WSTRB, M_WSTRB;
  logic        M_REQ, M_WE, M_ACK;
  logic [31:0] M_ADDR, M_WDATA, M_RDATA;

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_READY(I_READY),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
    .D_RDATA(D_RDATA), .D_READY(D_READY), .BUS_ERR(BUS_ERR),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_RDATA(M_RDATA), .M_ACK(M_ACK)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rdata;
  } exp_t;

  exp_t exp_q[$];
  int   ready_cyc_q[$];
  int   n_ready = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Memory model controls
  int          ack_delay = 0;
  bit          ack_never = 0;
  bit          force_ack = 0;
  logic [31:0] mem_rdata = 32'h0;
  int          mcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rd, input bit err);
    exp_t e;
    e.is_d      = is_d;
    e.we        = we;
    e.addr      = addr;
    e.wdata     = wdata;
    e.wstrb     = wstrb;
    e.rdata     = rd;
    e.err       = err;
    e.chk_rdata = !(is_d && we);
    return e;
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Memory: acks ack_delay cycles after M_REQ rises; drives junk read data when not acking.
  initial begin
    M_ACK   = 1'b0;
    M_RDATA = 32'hBAD0_BAD0;
    forever begin
      @(posedge CLK);
      #1;
      if (M_REQ) begin
        if (!ack_never && mcnt == ack_delay) begin
          M_ACK   = 1'b1;
          M_RDATA = mem_rdata;
        end else begin
          M_ACK   = 1'b0;
          M_RDATA = 32'hBAD0_BAD0;
        end
        mcnt++;
      end else begin
        M_ACK   = force_ack;
        M_RDATA = 32'hBAD0_BAD0;
        mcnt    = 0;
      end
    end
  end

  // Monitor: compare every completion against the head of the scoreboard
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (I_READY || D_READY) begin
      chk("one_ready", {I_READY, D_READY} == 2'b11, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ready_port", D_READY, e.is_d);
        chk("bus_err", BUS_ERR, e.err);
        chk("m_req_at_ready", M_REQ, 1);
        if (e.chk_rdata) chk("rdata", e.is_d ? D_RDATA : I_RDATA, e.rdata);
        chk("m_addr", M_ADDR, e.addr);
        chk("m_we", M_WE, e.we);
        chk("m_wdata", M_WDATA, e.wdata);
        chk("m_wstrb", M_WSTRB, e.wstrb);
      end
      ready_cyc_q.push_back(cyc);
      n_ready++;
    end else begin
      chk("idle_rdata", {I_RDATA, D_RDATA}, 0);
      chk("idle_bus_err", BUS_ERR, 0);
    end
  end

  task automatic wait_ready(input int tgt, input int budget, output bit seen);
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge CLK);
      #1;
      if (n_ready >= tgt) seen = 1;
    end
    chk("ready_within_budget", seen, 1);
  endtask

  task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rd, input bit err, input int lat,
                        input bit scramble);
    int c0, tgt;
    bit seen;
    exp_q.push_back(mk(is_d, we, addr, is_d ? wdata : 32'h0, is_d ? wstrb : 4'h0, rd, err));
    @(posedge CLK);
    #1;
    if (is_d) begin
      D_REQ = 1; D_WE = we; D_ADDR = addr; D_WDATA = wdata; D_WSTRB = wstrb;
    end else begin
      I_REQ = 1; I_ADDR = addr;
    end
    c0  = cyc;
    tgt = n_ready + 1;
    if (scramble) begin
      @(posedge CLK);
      #1;
      I_ADDR  = I_ADDR ^ 32'h0000_FFF0;
      D_ADDR  = D_ADDR ^ 32'h0000_FFF0;
      D_WDATA = ~D_WDATA;
    end
    wait_ready(tgt, 40, seen);
    I_REQ = 0;
    D_REQ = 0;
    if (seen) begin
      chk("latency", ready_cyc_q[$] - c0, lat);
      chk("m_req_dropped", M_REQ, 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    RESET = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    int  base, c0, tgt;
    bit  seen;
    RESET = 0; I_REQ = 0; I_ADDR = 0; D_REQ = 0; D_WE = 0; D_ADDR = 0; D_WDATA = 0; D_WSTRB = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_m_req", M_REQ, 0);
    chk("rst_m_payload", {M_WE, M_ADDR, M_WDATA, M_WSTRB}, 0);
    chk("rst_ready", {I_READY, D_READY, BUS_ERR}, 0);
    chk("rst_rdata", {I_RDATA, D_RDATA}, 0);
    @(negedge CLK);
    RESET = 1;

    // Fetch, ack 2 cycles after M_REQ; requester address changes mid-transaction
    ack_delay = 2; ack_never = 0; mem_rdata = 32'h0050_0093;
    do_txn(0, 0, 32'h0000_0010, 0, 0, 32'h0050_0093, 0, 3, 1);

    // Store with immediate ack
    ack_delay = 0; mem_rdata = 32'h1111_2222;
    do_txn(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 0, 0, 1, 0);

    // Load with immediate ack
    mem_rdata = 32'h7654_3210;
    do_txn(1, 0, 32'h0000_0104, 32'h0, 4'h0, 32'h7654_3210, 0, 1, 0);

    // M_ACK while IDLE must not complete anything
    @(negedge CLK); force_ack = 1;
    @(negedge CLK);
    @(negedge CLK); force_ack = 0;
    @(posedge CLK); #1;
    chk("idle_ack_no_req", M_REQ, 0);

    // Watchdog: D load never acked, then I fetch never acked, then ack in the expiry cycle
    ack_never = 1;
    do_txn(1, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 1, 4, 0);
    do_txn(0, 0, 32'h0000_0044, 32'h0, 4'h0, 32'h0, 1, 4, 0);
    ack_never = 0; ack_delay = 3; mem_rdata = 32'hCAFE_F00D;
    do_txn(1, 0, 32'h0000_0048, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 4, 0);

    // Contention from a fresh reset: both held, immediate ack
    pulse_reset();
    ack_delay = 0; mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      if (k % 2 == 0) exp_q.push_back(mk(1, 0, 32'h300, 0, 0, 32'h1234_5678, 0));
      else            exp_q.push_back(mk(0, 0, 32'h200, 0, 0, 32'h1234_5678, 0));
`else
      exp_q.push_back(mk(1, 0, 32'h300, 0, 0, 32'h1234_5678, 0));
`endif
    end
    @(posedge CLK); #1;
    I_REQ = 1; I_ADDR = 32'h200;
    D_REQ = 1; D_WE = 0; D_ADDR = 32'h300; D_WDATA = 0; D_WSTRB = 0;
    c0   = cyc;
    base = ready_cyc_q.size();
    tgt  = n_ready + 6;
    wait_ready(tgt, 60, seen);
    I_REQ = 0; D_REQ = 0;
    if (seen) begin
      chk("contend_first_latency", ready_cyc_q[base] - c0, 1);
      for (int k = 1; k < 6; k++) chk("contend_spacing", ready_cyc_q[base+k] - ready_cyc_q[base+k-1], 2);
    end

    // Asynchronous reset in the middle of a fetch, then a fresh grant
    ack_never = 1;
    @(posedge CLK); #1;
    I_REQ = 1; I_ADDR = 32'h80;
    @(posedge CLK); #1;
    chk("busy_m_req", M_REQ, 1);
    chk("busy_m_addr", M_ADDR, 32'h80);
    @(negedge CLK); #2;
    RESET = 0;
    #1;
    chk("async_rst_m_req", M_REQ, 0);
    chk("async_rst_ready", {I_READY, BUS_ERR}, 0);
    chk("async_rst_m_addr", M_ADDR, 0);
    I_ADDR = 32'h84; ack_never = 0; ack_delay = 0; mem_rdata = 32'h0BAD_CAFE;
    exp_q.push_back(mk(0, 0, 32'h84, 0, 0, 32'h0BAD_CAFE, 0));
    tgt = n_ready + 1;
    @(negedge CLK); #2;
    RESET = 1;
    wait_ready(tgt, 20, seen);
    I_REQ = 0;

    repeat (4) @(posedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
